car_stim_gen: RTL and testbench
===============================

# car_stim_gen

Synthesizable stimulus generator that drives the increment/decrement inputs of the car counter and its checking monitor. After a start request it emits a fixed number of one-cycle events: increment-only, decrement-only, alternating, or LFSR-pseudo-random. It sits on the input side of the counter and produces the same `inc`/`dec` pattern the monitor consumes as expected values, so benches and on-board self-test get repeatable traffic.

## Interface
- `NUM_EVENTS`, 64: events emitted per run, 1..255.
- `GAP`, 1: idle cycles between events, 0..15; 0 means back-to-back.
- `SEED`, 8'hA5: LFSR reload value; 8'h00 is replaced by 8'h01.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE.
- `mode`  in  2  00 inc-only, 01 dec-only, 10 alternate (inc first), 11 random; latched when a run starts.
- `inc_exp`  out  1  one-cycle increment pulse.
- `dec_exp`  out  1  one-cycle decrement pulse.
- `busy`  out  1  high in RUN and GAP.
- `done`  out  1  high in DONE.
- `event_cnt`  out  8  events emitted in the current run.

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE:
  - On `start`=1, latch `mode`, clear `event_cnt`, go to RUN.
  - LFSR holds its value; it is not reloaded.
- RUN (one cycle per event):
  - Assert the event, then increment `event_cnt`.
  - Random mode advances the LFSR once.
  - If `event_cnt`+1 == NUM_EVENTS, go to DONE.
  - Else go to GAP, or stay in RUN when GAP=0.
- GAP: count GAP idle cycles with both pulses low, then return to RUN.
- DONE: hold `done`=1 until `start`=0, then go to IDLE. `start` held high does not retrigger a run.
- Alternate mode: the toggle resets to inc at each run start.
- Random mode:
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4, shifting left with the feedback into bit 0.
  - `lfsr[0]`=1 gives inc; 0 gives dec.
- Outside RUN, `inc_exp`=`dec_exp`=0.
- `event_cnt` width is 8 bits and it never wraps, because NUM_EVENTS ≤ 255.
- Reset values: `inc_exp`=0, `dec_exp`=0, `busy`=0, `done`=0, `event_cnt`=0. State goes to IDLE and the LFSR goes to SEED.
- Reset mid-run: outputs take their reset values at the next edge and the run is abandoned. No event is emitted in the reset cycle.
- `mode` changes during a run are ignored.

## Timing
- `start` sampled high in IDLE at edge N: first pulse is visible after edge N+1.
- Event k+1 occurs GAP+1 cycles after event k.
- A full run takes NUM_EVENTS + (NUM_EVENTS−1)·GAP cycles in RUN/GAP.
- `done` rises on the edge following the final pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CAR_STIM_GEN_BOTH_EN`.
- Defined: in random mode, `lfsr[1:0]`==2'b11 asserts `inc_exp` and `dec_exp` together in the same cycle. This exercises the counter's inc-priority rule. It counts as one event.
- Undefined: `inc_exp` and `dec_exp` are never high in the same cycle.

## Structure
- Shared package `car_stim_pkg` holds:
  - the state enum (IDLE/RUN/GAP/DONE);
  - mode constants MODE_INC, MODE_DEC, MODE_ALT, MODE_RND;
  - LFSR tap mask 8'hB8.
- One sub-module, `lfsr8`, with ports `clk`, `rst`, `en`, `seed`, `q[7:0]`.

## Test plan
- NUM_EVENTS=4, GAP=1, mode=00, start pulse → `inc_exp` high on 4 cycles spaced 2 apart, `dec_exp`=0 throughout, `done`=1 with `event_cnt`=4.
- mode=10, GAP=0, NUM_EVENTS=5 → back-to-back sequence inc, dec, inc, dec, inc; `busy` high for exactly 5 cycles.
- mode=11, SEED=8'hA5, NUM_EVENTS=16, run twice with reset between → identical inc/dec sequences. With the macro undefined, inc and dec are never both high.
- `rst` asserted after the 3rd of 8 events → next cycle all outputs 0 and state IDLE. A new start restarts the run from `event_cnt`=0.
- `start` held high through DONE → no second run. Dropping `start` returns to IDLE; raising it again starts a new run.
- With `CAR_STIM_GEN_BOTH_EN`, mode=11, NUM_EVENTS=64 → at least one cycle with both pulses high, and `event_cnt`=64 at `done`.

Source files
------------

// File: rtl/car_stim_pkg.sv
// rtl/car_stim_pkg.sv - shared types and constants for the car counter stimulus generator
package car_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INC = 2'b00;
    localparam logic [1:0] MODE_DEC = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;
    localparam logic [1:0] MODE_RND = 2'b11;

    // Taps 8,6,5,4 of the 8-bit Fibonacci LFSR
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One left shift with the XOR of the tapped bits fed into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/car_stim_gen_if.sv
// rtl/car_stim_gen_if.sv - control and event-pulse bundle between the stimulus generator and its user
interface car_stim_gen_if;
    logic       start;
    logic [1:0] mode;
    logic       inc_exp;
    logic       dec_exp;
    logic       busy;
    logic       done;
    logic [7:0] event_cnt;

    // The generator is the source of the event stream
    modport master (
        input  start,
        input  mode,
        output inc_exp,
        output dec_exp,
        output busy,
        output done,
        output event_cnt
    );

    modport slave (
        output start,
        output mode,
        input  inc_exp,
        input  dec_exp,
        input  busy,
        input  done,
        input  event_cnt
    );
endinterface

// File: rtl/car_stim_gen_lfsr8.sv
// rtl/car_stim_gen_lfsr8.sv - 8-bit Fibonacci LFSR with enable and reset-time seed load
module lfsr8
    import car_stim_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;
    logic [7:0] seed_safe;

    // The all-zero state locks the LFSR, so a zero seed is replaced by 1
    assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;

    // Advance only when enabled; otherwise hold the current value
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = lfsr_next(q_q);
        end
    end

    // State register, loaded with the seed only on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed_safe;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/car_stim_gen.sv
// rtl/car_stim_gen.sv - inc/dec event stimulus generator for the car counter; optional CAR_STIM_GEN_BOTH_EN
module car_stim_gen
    import car_stim_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 64,
    parameter int unsigned GAP        = 1,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    car_stim_gen_if.master bus
);

    localparam logic [7:0] NUM_LAST = 8'(NUM_EVENTS - 1);
    localparam bit         GAP_ZERO = (GAP == 0);
    localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic       alt_q, alt_d;
    logic       inc_q, dec_q, busy_q, done_q;

    logic       ev_inc, ev_dec;
    logic       lfsr_en;
    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    // Random mode consumes one LFSR step per emitted event
    assign lfsr_en = (state_q == ST_RUN) && (mode_q == MODE_RND);

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .seed (SEED),
        .q    (lfsr_q)
    );

    // Only the two low bits decide the event; the rest just feed the shift
    assign lfsr_unused = ^lfsr_q[7:2];

    // Direction of the event the RUN state would emit this cycle
    always_comb begin
        ev_inc = 1'b0;
        ev_dec = 1'b0;
        case (mode_q)
            MODE_INC: ev_inc = 1'b1;
            MODE_DEC: ev_dec = 1'b1;
            MODE_ALT: begin
                ev_inc = ~alt_q;
                ev_dec = alt_q;
            end
            default: begin
                ev_inc = lfsr_q[0];
                ev_dec = ~lfsr_q[0];
`ifdef CAR_STIM_GEN_BOTH_EN
                if (lfsr_q[1:0] == 2'b11) begin
                    ev_dec = 1'b1;
                end
`endif
            end
        endcase
    end

    // Next-state logic: run sequencing, event counting, gap timing
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        alt_d   = alt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    mode_d  = bus.mode;
                    cnt_d   = 8'd0;
                    alt_d   = 1'b0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 8'd1;
                alt_d = ~alt_q;
                gap_d = 4'd0;
                if (cnt_q == NUM_LAST) begin
                    state_d = ST_DONE;
                end else if (GAP_ZERO) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_DONE: begin
                // A start held high across DONE must not retrigger
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and run-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            cnt_q   <= 8'd0;
            gap_q   <= 4'd0;
            alt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            alt_q   <= alt_d;
        end
    end

    // Registered outputs, one cycle behind the state that produces them
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inc_q  <= (state_q == ST_RUN) && ev_inc;
            dec_q  <= (state_q == ST_RUN) && ev_dec;
            busy_q <= (state_q == ST_RUN) || (state_q == ST_GAP);
            done_q <= (state_q == ST_DONE);
        end
    end

    assign bus.inc_exp   = inc_q;
    assign bus.dec_exp   = dec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.event_cnt = cnt_q;

endmodule

// File: tb/tb_car_stim_gen.sv
// tb/tb_car_stim_gen.sv - self-checking bench for car_stim_gen with a timing-based reference model
module tb_car_stim_gen;
    import car_stim_pkg::*;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_r [ND];
    logic [1:0] mode_r  [ND];
    logic       inc_v   [ND];
    logic       dec_v   [ND];
    logic       busy_v  [ND];
    logic       done_v  [ND];
    logic [7:0] cnt_v   [ND];

    car_stim_gen_if if0 ();
    car_stim_gen_if if1 ();
    car_stim_gen_if if2 ();

    assign if0.start = start_r[0];
    assign if0.mode  = mode_r[0];
    assign if1.start = start_r[1];
    assign if1.mode  = mode_r[1];
    assign if2.start = start_r[2];
    assign if2.mode  = mode_r[2];

    assign inc_v[0] = if0.inc_exp;  assign dec_v[0] = if0.dec_exp;
    assign busy_v[0] = if0.busy;    assign done_v[0] = if0.done;   assign cnt_v[0] = if0.event_cnt;
    assign inc_v[1] = if1.inc_exp;  assign dec_v[1] = if1.dec_exp;
    assign busy_v[1] = if1.busy;    assign done_v[1] = if1.done;   assign cnt_v[1] = if1.event_cnt;
    assign inc_v[2] = if2.inc_exp;  assign dec_v[2] = if2.dec_exp;
    assign busy_v[2] = if2.busy;    assign done_v[2] = if2.done;   assign cnt_v[2] = if2.event_cnt;

    car_stim_gen #(.NUM_EVENTS(4),  .GAP(1), .SEED(8'hA5)) u0 (.clk(clk), .rst(rst), .bus(if0));
    car_stim_gen #(.NUM_EVENTS(5),  .GAP(0), .SEED(8'h3C)) u1 (.clk(clk), .rst(rst), .bus(if1));
    car_stim_gen #(.NUM_EVENTS(16), .GAP(2), .SEED(8'hA5)) u2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int p_ne(int d);
        case (d) 0: return 4; 1: return 5; default: return 16; endcase
    endfunction
    function automatic int p_gap(int d);
        case (d) 0: return 1; 1: return 0; default: return 2; endcase
    endfunction
    function automatic logic [7:0] p_seed(int d);
        case (d) 1: return 8'h3C; default: return 8'hA5; endcase
    endfunction
    function automatic logic [7:0] m_step(logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: phase 0 idle, 1 running, 2 holding done
    int         ph  [ND];
    int         rel [ND];
    logic [1:0] md  [ND];
    logic [7:0] lf  [ND];
    int e_inc [ND], e_dec [ND], e_busy [ND], e_done [ND], e_cnt [ND];
    bit m_valid = 1'b0;

    // Monitor
    int n_inc [ND], n_dec [ND], n_both [ND], n_busy [ND];
    logic [1:0] seq [ND][$];
    int ptime [$];

    task automatic chk(string nm, int act, int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Predict outputs after the next rising edge from the inputs it will sample
    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            int ne, g, last, k;
            ne = p_ne(d);
            g = p_gap(d);
            last = 1 + (ne - 1) * (g + 1);
            if (rst) begin
                ph[d] = 0; e_inc[d] = 0; e_dec[d] = 0; e_busy[d] = 0; e_done[d] = 0;
                e_cnt[d] = 0; lf[d] = p_seed(d);
            end else begin
                e_inc[d] = 0; e_dec[d] = 0; e_busy[d] = 0; e_done[d] = 0;
                if (ph[d] == 1) begin
                    rel[d]++;
                    if (rel[d] <= last) begin
                        e_busy[d] = 1;
                        if ((rel[d] - 1) % (g + 1) == 0) begin
                            k = (rel[d] - 1) / (g + 1);
                            case (md[d])
                                2'b00: e_inc[d] = 1;
                                2'b01: e_dec[d] = 1;
                                2'b10: begin
                                    e_inc[d] = (k % 2 == 0) ? 1 : 0;
                                    e_dec[d] = 1 - e_inc[d];
                                end
                                default: begin
                                    e_inc[d] = lf[d][0] ? 1 : 0;
                                    e_dec[d] = 1 - e_inc[d];
`ifdef CAR_STIM_GEN_BOTH_EN
                                    if (lf[d][1:0] == 2'b11) e_dec[d] = 1;
`endif
                                    lf[d] = m_step(lf[d]);
                                end
                            endcase
                            e_cnt[d] = k + 1;
                        end
                    end else begin
                        ph[d] = 2;
                    end
                end
                if (ph[d] == 2) begin
                    e_done[d] = 1;
                    if (!start_r[d]) ph[d] = 0;
                end else if (ph[d] == 0 && start_r[d]) begin
                    ph[d] = 1;
                    rel[d] = 0;
                    md[d] = mode_r[d];
                    e_cnt[d] = 0;
                end
            end
        end
    endtask

    // Compare every DUT output against the model each cycle, then advance the model
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (m_valid) begin
                chk($sformatf("dut%0d inc_exp", d), int'(inc_v[d]), e_inc[d]);
                chk($sformatf("dut%0d dec_exp", d), int'(dec_v[d]), e_dec[d]);
                chk($sformatf("dut%0d busy", d), int'(busy_v[d]), e_busy[d]);
                chk($sformatf("dut%0d done", d), int'(done_v[d]), e_done[d]);
                chk($sformatf("dut%0d event_cnt", d), int'(cnt_v[d]), e_cnt[d]);
            end
            if (inc_v[d] || dec_v[d]) begin
                seq[d].push_back({inc_v[d], dec_v[d]});
                if (d == 0) ptime.push_back(cyc);
            end
            if (inc_v[d]) n_inc[d]++;
            if (dec_v[d]) n_dec[d]++;
            if (inc_v[d] && dec_v[d]) n_both[d]++;
            if (busy_v[d]) n_busy[d]++;
        end
        model_step();
        m_valid = 1'b1;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic clr_mon();
        for (int d = 0; d < ND; d++) begin
            n_inc[d] = 0; n_dec[d] = 0; n_both[d] = 0; n_busy[d] = 0;
            seq[d].delete();
        end
        ptime.delete();
    endtask

    logic [1:0] run1 [$];

    initial begin
        int d, hold, waited;
        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            start_r[i] = 1'b0;
            mode_r[i] = 2'b00;
        end
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("reset inc_exp", int'(inc_v[0]), 0);
        chk("reset dec_exp", int'(dec_v[0]), 0);
        chk("reset busy", int'(busy_v[0]), 0);
        chk("reset done", int'(done_v[0]), 0);
        chk("reset event_cnt", int'(cnt_v[2]), 0);
        chk("model lfsr step A5", int'(m_step(8'hA5)), 8'h4A);

        // Inc-only, GAP=1, four events, start held through DONE
        clr_mon();
        mode_r[0] = MODE_INC;
        start_r[0] = 1'b1;
        tick(30);
        chk("A inc pulses", n_inc[0], 4);
        chk("A dec pulses", n_dec[0], 0);
        chk("A pulse count", ptime.size(), 4);
        for (int i = 1; i < ptime.size(); i++) chk("A pulse spacing", ptime[i] - ptime[i-1], 2);
        chk("A done held", int'(done_v[0]), 1);
        chk("A event_cnt at done", int'(cnt_v[0]), 4);
        start_r[0] = 1'b0;
        tick(3);
        chk("A done cleared", int'(done_v[0]), 0);
        clr_mon();
        start_r[0] = 1'b1;
        tick(1);
        start_r[0] = 1'b0;
        tick(15);
        chk("A rerun inc pulses", n_inc[0], 4);

        // Alternate, GAP=0, mode wiggled during the run
        clr_mon();
        mode_r[1] = MODE_ALT;
        start_r[1] = 1'b1;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            mode_r[1] = 2'($urandom);
            tick(1);
        end
        start_r[1] = 1'b0;
        chk("B event count", seq[1].size(), 5);
        for (int i = 0; i < seq[1].size(); i++) chk("B alt pattern", int'(seq[1][i]), (i % 2 == 0) ? 2 : 1);
        chk("B busy cycles", n_busy[1], 5);

        // Random mode twice with a reset between runs
        clr_mon();
        mode_r[2] = MODE_RND;
        start_r[2] = 1'b1;
        tick(60);
        run1 = seq[2];
        start_r[2] = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clr_mon();
        start_r[2] = 1'b1;
        tick(60);
        start_r[2] = 1'b0;
        chk("C run1 length", run1.size(), 16);
        chk("C run2 length", seq[2].size(), 16);
        for (int i = 0; i < run1.size() && i < seq[2].size(); i++) chk("C repeat seq", int'(seq[2][i]), int'(run1[i]));
        if (run1.size() > 0) chk("C first event inc", int'(run1[0]), 2);
        else chk("C first event present", 0, 1);
`ifdef CAR_STIM_GEN_BOTH_EN
        chk("C both pulses seen", (n_both[2] > 0) ? 1 : 0, 1);
`else
        chk("C no both pulses", n_both[2], 0);
`endif
        tick(3);

        // Reset after the third event, then restart from zero
        clr_mon();
        mode_r[2] = MODE_DEC;
        start_r[2] = 1'b1;
        waited = 0;
        while (seq[2].size() < 3 && waited < 100) begin
            tick(1);
            waited++;
        end
        chk("D reached 3 events", (seq[2].size() >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        tick(1);
        chk("D reset inc_exp", int'(inc_v[2]), 0);
        chk("D reset dec_exp", int'(dec_v[2]), 0);
        chk("D reset busy", int'(busy_v[2]), 0);
        chk("D reset done", int'(done_v[2]), 0);
        chk("D reset event_cnt", int'(cnt_v[2]), 0);
        rst = 1'b0;
        clr_mon();
        tick(60);
        chk("D restart events", seq[2].size(), 16);
        chk("D restart event_cnt", int'(cnt_v[2]), 16);
        start_r[2] = 1'b0;
        tick(3);

        // Randomized runs, mode noise and occasional resets
        for (int it = 0; it < 25; it++) begin
            d = $urandom_range(0, 2);
            mode_r[d] = 2'($urandom);
            start_r[d] = 1'b1;
            hold = $urandom_range(1, 70);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 3) == 0) mode_r[d] = 2'($urandom);
                rst = ($urandom_range(0, 149) == 0);
                tick(1);
            end
            rst = 1'b0;
            start_r[d] = 1'b0;
            tick($urandom_range(0, 20));
        end
        tick(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
